// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared constants and types for the multi-cycle MIPS core.
// Opcodes, funct codes, FSM state and ALU operation encodings.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// mips_mc_if: shared instruction/data memory port with req/ready handshake.
// The core is the master; the memory model is the slave.
interface mips_mc_if;
    import mips_mc_pkg::*;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one write port.
// $0 reads as zero and ignores writes; $29 resets to the stack pointer.
module mips_regfile
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (i == 29) ? SP_INIT : 32'h0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : r_regs[i_raddr2];

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS32-subset core on a shared memory port.
// Each instruction walks a sequence of FSM states; ALU and FSM are inline.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] SP_INIT         = 32'h0000_3FFC,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    mips_mc_if.master   bus,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  dbg_state
);

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic        r_illegal, w_illegal_set;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm, w_ea, w_alu_y;
    logic [31:0] w_rs_val, w_rt_val;
    alu_op_t     w_alu_op;
    logic        w_fn_ok;

    logic        w_access, w_we;
    logic [31:0] w_addr;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    assign w_op  = r_ir[31:26];
    assign w_rs  = r_ir[25:21];
    assign w_rt  = r_ir[20:16];
    assign w_rd  = r_ir[15:11];
    assign w_fn  = r_ir[5:0];
    assign w_imm = sext16(r_ir[15:0]);
    assign w_ea  = r_a + w_imm;

    mips_regfile #(.SP_INIT(SP_INIT)) u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .i_we     (w_rf_we),
        .i_waddr  (w_rf_waddr),
        .i_wdata  (w_rf_wdata),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_val),
        .o_rdata2 (w_rt_val)
    );

    always_comb begin
        w_alu_op = ALU_ADD;
        w_fn_ok  = 1'b1;
        unique case (1'b1)
            (w_fn == FN_ADD): w_alu_op = ALU_ADD;
            (w_fn == FN_SUB): w_alu_op = ALU_SUB;
            (w_fn == FN_AND): w_alu_op = ALU_AND;
            (w_fn == FN_OR):  w_alu_op = ALU_OR;
            (w_fn == FN_SLT): w_alu_op = ALU_SLT;
            default:          w_fn_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_y = r_a + r_b;
        case (w_alu_op)
            ALU_SUB: w_alu_y = r_a - r_b;
            ALU_AND: w_alu_y = r_a & r_b;
            ALU_OR:  w_alu_y = r_a | r_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(r_a) < $signed(r_b)};
            default: ;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_illegal_set = 1'b0;
        w_access      = 1'b0;
        w_we          = 1'b0;
        w_addr        = r_pc;
        w_rf_we       = 1'b0;
        w_rf_waddr    = w_rt;
        w_rf_wdata    = r_aluout;
        unique case (r_state)
            FETCH: begin
                w_access = 1'b1;
                if (bus.mem_ready) w_next = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    (w_op == OP_LW) || (w_op == OP_SW):
                        w_next = MEMADR;
                    (w_op == OP_RTYPE) && (w_fn == FN_SYSCALL):
                        w_next = HALT_ON_SYSCALL ? HALT : FETCH;
                    (w_op == OP_RTYPE) && w_fn_ok:
                        w_next = EXEC;
                    (w_op == OP_BEQ):  w_next = BRANCH;
                    (w_op == OP_ADDI): w_next = ADDIEX;
                    (w_op == OP_J):    w_next = JUMP;
                    default: begin
                        w_next        = HALT;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                // a misaligned address never reaches the bus
                if (w_ea[1:0] != 2'b00) begin
                    w_next        = HALT;
                    w_illegal_set = 1'b1;
                end else begin
                    w_next = (w_op == OP_SW) ? MEMWR : MEMRD;
                end
            end
            MEMRD: begin
                w_access = 1'b1;
                w_addr   = r_aluout;
                if (bus.mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_mdr;
                w_next     = FETCH;
            end
            MEMWR: begin
                w_access = 1'b1;
                w_we     = 1'b1;
                w_addr   = r_aluout;
                if (bus.mem_ready) w_next = FETCH;
            end
            EXEC:   w_next = ALUWB;
            ALUWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
                w_next     = FETCH;
            end
            BRANCH: w_next = FETCH;
            ADDIEX: w_next = ADDIWB;
            ADDIWB: begin
                w_rf_we = 1'b1;
                w_next  = FETCH;
            end
            JUMP:   w_next = FETCH;
            HALT:   ;
            default: begin
                w_next        = HALT;
                w_illegal_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_illegal_set) r_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
            r_mdr    <= 32'h0;
        end else begin
            case (r_state)
                FETCH: if (bus.mem_ready) begin
                    r_ir <= bus.mem_rdata;
                    r_pc <= r_pc + 32'd4;
                end
                DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    r_aluout <= r_pc + (w_imm << 2);
                end
                MEMADR, ADDIEX: r_aluout <= w_ea;
                MEMRD: if (bus.mem_ready) r_mdr <= bus.mem_rdata;
                EXEC:   r_aluout <= w_alu_y;
                BRANCH: if (r_a == r_b) r_pc <= r_aluout;
                JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // reset forces the bus idle even though the state already reads FETCH
    assign bus.mem_req   = w_access & reset;
    assign bus.mem_we    = w_we & reset;
    assign bus.mem_addr  = reset ? w_addr : 32'h0;
    assign bus.mem_wdata = (reset && w_we) ? r_b : 32'h0;

    assign pc        = r_pc;
    assign halted    = (r_state == HALT);
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

endmodule
